// File: rtl/axi4_mult_burst_slave_pkg.sv
// Shared types for the AXI4 mult slave: response codes, channel FSM states
// and the operand beat-count helper.
package axi4_mult_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wstate_t;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RData
  } rstate_t;

  // Number of data beats per operand.
  function automatic int unsigned nb(input int unsigned sz, input int unsigned dsz);
    return sz / dsz;
  endfunction

endpackage

// File: rtl/axi4_mult_burst_slave_if.sv
// AXI4 write/read channel bundle for the mult slave.
interface axi4_mult_burst_slave_if #(
  parameter int unsigned DSZ  = 8,
  parameter int unsigned ASZ  = 4,
  parameter int unsigned LENW = 8
);
  logic [ASZ-1:0]   awaddr;
  logic [LENW-1:0]  awlen;
  logic             awvalid;
  logic             awready;
  logic [DSZ-1:0]   wdata;
  logic [DSZ/8-1:0] wstrb;
  logic             wvalid;
  logic             wready;
  logic             wlast;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [ASZ-1:0]   araddr;
  logic [LENW-1:0]  arlen;
  logic             arvalid;
  logic             arready;
  logic [DSZ-1:0]   rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic             rlast;

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    input  araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
  );

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    output araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi4_mult_rd_chan.sv
// AXI4 read channel: waits for a settled product, snapshots it, then streams
// the requested beat slice. Out-of-range beats return zero with SLVERR.
module axi4_mult_rd_chan
  import axi4_mult_pkg::*;
#(
  parameter int unsigned SZ   = 32,
  parameter int unsigned DSZ  = 8,
  parameter int unsigned ASZ  = 4,
  parameter int unsigned LENW = 8
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic [ASZ-1:0]  i_araddr,
  input  logic [LENW-1:0] i_arlen,
  input  logic            i_arvalid,
  output logic            o_arready,
  output logic [DSZ-1:0]  o_rdata,
  output logic [1:0]      o_rresp,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic            o_rlast,
  input  logic            i_start,
  input  logic            i_mulready,
  input  logic [2*SZ-1:0] i_result
);
  localparam int unsigned NBEAT = 2 * nb(SZ, DSZ);
  localparam int unsigned IW    = $clog2(NBEAT);

  rstate_t                      r_state, w_state_d;
  logic [ASZ-1:0]               r_rptr;
  logic [LENW-1:0]              r_rcnt;
  logic [NBEAT-1:0][DSZ-1:0]    r_rbuf;
  logic                         w_go;
  logic                         w_in_range;

  assign w_go       = i_mulready && !i_start;
  assign w_in_range = 32'(r_rptr) < NBEAT;

  // State register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) r_state <= RIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      RIdle:   if (i_arvalid) w_state_d = RWait;
      RWait:   if (w_go) w_state_d = RData;
      RData:   if (i_rready && r_rcnt == '0) w_state_d = RIdle;
      default: w_state_d = RIdle;
    endcase
  end

  // Burst pointer, remaining count and result snapshot.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_rptr <= '0;
      r_rcnt <= '0;
      r_rbuf <= '0;
    end else begin
      if (r_state == RIdle && i_arvalid) begin
        r_rptr <= i_araddr;
        r_rcnt <= i_arlen;
      end
      // The snapshot is only taken here, so writes during RData leave it alone.
      if (r_state == RWait && w_go) r_rbuf <= i_result;
      if (r_state == RData && i_rready) begin
        r_rptr <= r_rptr + ASZ'(1);
        r_rcnt <= r_rcnt - LENW'(1);
      end
    end
  end

  // Channel outputs, all decoded from registered state.
  always_comb begin
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rdata   = '0;
    o_rresp   = OKAY;
    o_rlast   = 1'b0;
    unique case (r_state)
      RIdle: o_arready = 1'b1;
      RWait: ;
      RData: begin
        o_rvalid = 1'b1;
        o_rlast  = (r_rcnt == '0);
        if (w_in_range) o_rdata = r_rbuf[r_rptr[IW-1:0]];
        else            o_rresp = SLVERR;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mult.sv
// Two-cycle multiplier: start marks operands valid, product lands one cycle later.
module mult #(
  parameter int unsigned SZ = 32
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic          i_start,
  input  logic [SZ-1:0] i_a,
  input  logic [SZ-1:0] i_b,
  output logic [2*SZ-1:0] o_p,
  output logic          o_ready
);
  logic            r_busy;
  logic [2*SZ-1:0] r_p;
  logic [2*SZ-1:0] w_a_ext;
  logic [2*SZ-1:0] w_b_ext;

  assign w_a_ext = {{SZ{1'b0}}, i_a};
  assign w_b_ext = {{SZ{1'b0}}, i_b};

  // Busy for the cycle after start, then latch the product.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_busy <= 1'b0;
      r_p    <= '0;
    end else begin
      r_busy <= i_start;
      if (r_busy) r_p <= w_a_ext * w_b_ext;
    end
  end

  assign o_p     = r_p;
  assign o_ready = !r_busy;
endmodule

// File: rtl/axi4_mult_burst_slave.sv
// AXI4 INCR-burst slave front-end for the mult core. Write bursts load operand
// beats (A at 0..NB-1, B at NB..2NB-1); an OKAY write pulses start for one cycle.
// Build option AXIMUL_WSTRB_EN: honour wstrb byte enables on write beats.
module axi4_mult_burst_slave
  import axi4_mult_pkg::*;
#(
  parameter int unsigned SZ   = 32,
  parameter int unsigned DSZ  = 8,
  parameter int unsigned ASZ  = 4,
  parameter int unsigned LENW = 8
) (
  input logic                    clk,
  input logic                    _rst,
  axi4_mult_burst_slave_if.slave bus
);
  localparam int unsigned NB    = nb(SZ, DSZ);
  localparam int unsigned NBEAT = 2 * NB;
  localparam int unsigned IW    = $clog2(NBEAT);

  wstate_t                   r_wstate, w_wstate_d;
  logic [ASZ-1:0]            r_wptr;
  logic [LENW-1:0]           r_wcnt;
  logic [LENW-1:0]           r_wlen;
  logic                      r_err;
  logic                      r_start;
  logic [NBEAT-1:0][DSZ-1:0] r_op;
  logic [IW-1:0]             w_widx;
  logic                      w_w_hs;
  logic [SZ-1:0]             w_a;
  logic [SZ-1:0]             w_b;
  logic [2*SZ-1:0]           w_result;
  logic                      w_mulready;

  assign w_widx = r_wptr[IW-1:0];
  assign w_w_hs = (r_wstate == WData) && bus.wvalid;
  assign w_a    = r_op[NB-1:0];
  assign w_b    = r_op[NBEAT-1:NB];

`ifndef AXIMUL_WSTRB_EN
  logic w_unused_wstrb;
  assign w_unused_wstrb = ^bus.wstrb;
`endif

  // Write FSM state register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) r_wstate <= WIdle;
    else       r_wstate <= w_wstate_d;
  end

  // Write FSM next state; the burst ends only on wlast.
  always_comb begin
    w_wstate_d = r_wstate;
    unique case (r_wstate)
      WIdle:   if (bus.awvalid) w_wstate_d = WData;
      WData:   if (bus.wvalid && bus.wlast) w_wstate_d = WResp;
      WResp:   if (bus.bready) w_wstate_d = WIdle;
      default: w_wstate_d = WIdle;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = OKAY;
    unique case (r_wstate)
      WIdle: bus.awready = 1'b1;
      WData: bus.wready  = 1'b1;
      WResp: begin
        bus.bvalid = 1'b1;
        bus.bresp  = r_err ? SLVERR : OKAY;
      end
      default: ;
    endcase
  end

  // Write datapath: burst tracking, error flag, operand regs and start pulse.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_wptr  <= '0;
      r_wcnt  <= '0;
      r_wlen  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_op    <= '0;
    end else begin
      r_start <= (r_wstate == WResp) && bus.bready && !r_err;
      if (r_wstate == WIdle && bus.awvalid) begin
        r_wptr <= bus.awaddr;
        r_wcnt <= '0;
        r_wlen <= bus.awlen;
        r_err  <= 1'b0;
      end
      if (w_w_hs) begin
        if (32'(r_wptr) < NBEAT) begin
`ifdef AXIMUL_WSTRB_EN
          for (int k = 0; k < int'(DSZ / 8); k++) begin
            if (bus.wstrb[k]) r_op[w_widx][k*8 +: 8] <= bus.wdata[k*8 +: 8];
          end
`else
          r_op[w_widx] <= bus.wdata;
`endif
        end else begin
          r_err <= 1'b1;
        end
        // Early wlast, or the final counted beat without wlast.
        if (bus.wlast != (r_wcnt == r_wlen)) r_err <= 1'b1;
        r_wptr <= r_wptr + ASZ'(1);
        r_wcnt <= r_wcnt + LENW'(1);
      end
    end
  end

  mult #(
    .SZ (SZ)
  ) u_mult (
    .clk     (clk),
    ._rst    (_rst),
    .i_start (r_start),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_p     (w_result),
    .o_ready (w_mulready)
  );

  axi4_mult_rd_chan #(
    .SZ   (SZ),
    .DSZ  (DSZ),
    .ASZ  (ASZ),
    .LENW (LENW)
  ) u_rd_chan (
    .clk        (clk),
    ._rst       (_rst),
    .i_araddr   (bus.araddr),
    .i_arlen    (bus.arlen),
    .i_arvalid  (bus.arvalid),
    .o_arready  (bus.arready),
    .o_rdata    (bus.rdata),
    .o_rresp    (bus.rresp),
    .o_rvalid   (bus.rvalid),
    .i_rready   (bus.rready),
    .o_rlast    (bus.rlast),
    .i_start    (r_start),
    .i_mulready (w_mulready),
    .i_result   (w_result)
  );
endmodule

// File: tb/tb_axi4_mult_burst_slave.sv
// Directed bench for axi4_mult_burst_slave: a table of write/read bursts with
// hand-computed responses, plus sequences for stalls, concurrency and reset.
module tb_axi4_mult_burst_slave;
  localparam int unsigned SZ = 32, DSZ = 8, ASZ = 4, LENW = 8;

  logic clk = 1'b0;
  logic _rst;
  always #5 clk = ~clk;

  axi4_mult_burst_slave_if #(.DSZ(DSZ), .ASZ(ASZ), .LENW(LENW)) bus ();

  axi4_mult_burst_slave #(.SZ(SZ), .DSZ(DSZ), .ASZ(ASZ), .LENW(LENW)) dut (
    .clk  (clk),
    ._rst (_rst),
    .bus  (bus)
  );

  typedef struct {
    bit          is_rd;
    logic [3:0]  addr;
    logic [7:0]  len;
    int          last_at;  // write beat carrying wlast
    logic [63:0] data;     // write data or expected read data, beat 0 in the low byte
    logic [7:0]  strb;     // per-beat wstrb
    logic [1:0]  resp;     // expected bresp
    bit          start;    // expected start pulse
    logic [7:0]  rerr;     // per-beat: expect SLVERR
  } vec_t;

  int nchk = 0;
  int nerr = 0;
  int n_start = 0;
  int wn;

  always @(negedge clk) if (dut.r_start) n_start++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic aw_hs(input logic [3:0] a, input logic [7:0] l);
    bit hs;
    int n = 0;
    bus.awaddr = a; bus.awlen = l; bus.awvalid = 1'b1;
    do begin
      @(negedge clk); hs = bus.awready; @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    bus.awvalid = 1'b0;
    chk("aw_hs", hs, 1);
  endtask

  task automatic ar_hs(input logic [3:0] a, input logic [7:0] l);
    bit hs;
    int n = 0;
    bus.araddr = a; bus.arlen = l; bus.arvalid = 1'b1;
    do begin
      @(negedge clk); hs = bus.arready; @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    bus.arvalid = 1'b0;
    chk("ar_hs", hs, 1);
  endtask

  task automatic w_beat(input logic [7:0] d, input logic s, input bit last);
    bit hs;
    int n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
    do begin
      @(negedge clk); hs = bus.wready; @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("w_hs", hs, 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] l, input int last_at,
                          input logic [63:0] d, input logic [7:0] strb,
                          input logic [1:0] eresp, input bit estart, input string tag);
    bit hs;
    int n = 0;
    int s0 = 0;
    logic [1:0] resp = 2'b11;
    aw_hs(a, l);
    for (int b = 0; b <= last_at; b++) w_beat(d[b*8 +: 8], strb[b], b == last_at);
    bus.bready = 1'b1;
    do begin
      @(negedge clk); hs = bus.bvalid; resp = bus.bresp; s0 = n_start;
      @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    bus.bready = 1'b0;
    chk({tag, ".b_hs"}, hs, 1);
    chk({tag, ".bresp"}, resp, eresp);
    repeat (4) @(negedge clk);
    chk({tag, ".start_pulses"}, n_start - s0, estart);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] l, input logic [63:0] ed,
                         input logic [7:0] erer, input int stall_beat, input int stall_n,
                         input string tag);
    int n;
    logic [7:0] d;
    logic [1:0] r;
    logic last;
    ar_hs(a, l);
    for (int b = 0; b <= int'(l); b++) begin
      n = 0;
      @(negedge clk);
      while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
      chk($sformatf("%s.rvalid[%0d]", tag, b), bus.rvalid, 1);
      d = bus.rdata; r = bus.rresp; last = bus.rlast;
      chk($sformatf("%s.rdata[%0d]", tag, b), d, ed[b*8 +: 8]);
      chk($sformatf("%s.rresp[%0d]", tag, b), r, erer[b] ? 2'b10 : 2'b00);
      chk($sformatf("%s.rlast[%0d]", tag, b), last, b == int'(l));
      if (b == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          chk($sformatf("%s.stall[%0d]", tag, k), {bus.rvalid, bus.rdata, bus.rresp, bus.rlast},
              {1'b1, d, r, last});
        end
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".end"}, {bus.rvalid, bus.rlast, bus.rdata, bus.arready}, {1'b0, 1'b0, 8'h00, 1'b1});
    @(posedge clk); #1;
  endtask

  vec_t vec [10];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{0, 4'd0, 8'd3, 3, 64'h05,                  8'hFF, 2'b00, 1, 8'h00};
    vec[1] = '{0, 4'd4, 8'd3, 3, 64'h07,                  8'hFF, 2'b00, 1, 8'h00};
    vec[2] = '{1, 4'd0, 8'd7, 0, 64'h23,                  8'hFF, 2'b00, 0, 8'h00};
    vec[3] = '{0, 4'd0, 8'd7, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 1, 8'h00};
    vec[4] = '{1, 4'd2, 8'd3, 0, 64'hFFFE_0000,           8'hFF, 2'b00, 0, 8'h00};
    vec[5] = '{0, 4'd6, 8'd3, 3, 64'h4433_2211,           8'hFF, 2'b10, 0, 8'h00};
    vec[6] = '{1, 4'd6, 8'd1, 0, 64'hFFFF,                8'hFF, 2'b00, 0, 8'h00};
    vec[7] = '{1, 4'd8, 8'd0, 0, 64'h00,                  8'hFF, 2'b00, 0, 8'h01};
    vec[8] = '{1, 4'd7, 8'd1, 0, 64'h00FF,                8'hFF, 2'b00, 0, 8'h02};
    vec[9] = '{0, 4'd0, 8'd0, 1, 64'h0000,                8'hFF, 2'b10, 0, 8'h00};

    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '1; bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    _rst = 1'b0;
    #12;
    chk("reset.ready", {bus.awready, bus.arready, bus.wready}, 3'b110);
    chk("reset.outs", {bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, bus.rresp, bus.rlast}, '0);
    chk("reset.start", dut.r_start, 0);
    _rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vec[i].is_rd)
        do_read(vec[i].addr, vec[i].len, vec[i].data, vec[i].rerr, -1, 0, $sformatf("v%0d", i));
      else
        do_write(vec[i].addr, vec[i].len, vec[i].last_at, vec[i].data, vec[i].strb,
                 vec[i].resp, vec[i].start, $sformatf("v%0d", i));
    end

    // Early wlast, then a read stalled five cycles mid-burst; product is still FFFF_FFFF squared.
    do_write(4'd0, 8'd3, 1, 64'h0003, 8'hFF, 2'b10, 0, "t4.wr");
    do_read(4'd0, 8'd7, 64'hFFFF_FFFE_0000_0001, 8'h00, 3, 5, "t4.rd");

    // OKAY write lands while a read burst is stalled in its data phase.
    do_write(4'd0, 8'd7, 7, 64'h0000_0003_0000_0002, 8'hFF, 2'b00, 1, "t5.setup");
    fork
      do_read(4'd0, 8'd7, 64'h06, 8'h00, 0, 20, "t5.rd");
      begin
        repeat (4) @(posedge clk);
        #1;
        do_write(4'd0, 8'd0, 0, 64'h05, 8'hFF, 2'b00, 1, "t5.wr");
      end
    join
    do_read(4'd0, 8'd0, 64'h0F, 8'h00, -1, 0, "t5.after");

    // Reset during the write data phase.
    aw_hs(4'd0, 8'd3);
    w_beat(8'h09, 1'b1, 1'b0);
    @(negedge clk);
    #2 _rst = 1'b0;
    #1;
    chk("t6w.ready", {bus.awready, bus.wready, bus.arready}, 3'b101);
    chk("t6w.resp", {bus.bvalid, bus.bresp, bus.rvalid}, '0);
    @(posedge clk);
    #3 _rst = 1'b1;
    @(posedge clk); #1;
    do_write(4'd0, 8'd7, 7, 64'h0000_0006_0000_0004, 8'hFF, 2'b00, 1, "t6.wr");
    do_read(4'd0, 8'd7, 64'h18, 8'h00, -1, 0, "t6.rd");

    // Reset during the read data phase.
    ar_hs(4'd0, 8'd7);
    wn = 0;
    @(negedge clk);
    while (!bus.rvalid && wn < 50) begin @(negedge clk); wn++; end
    chk("t6r.active", {bus.rvalid, bus.rdata}, {1'b1, 8'h18});
    #2 _rst = 1'b0;
    #1;
    chk("t6r.outs", {bus.rvalid, bus.rlast, bus.rdata, bus.rresp}, '0);
    chk("t6r.ready", {bus.arready, bus.awready}, 2'b11);
    @(posedge clk);
    #3 _rst = 1'b1;
    @(posedge clk); #1;
    do_read(4'd0, 8'd0, 64'h00, 8'h00, -1, 0, "t6.rd2");

    // wstrb: zero strobe leaves the byte alone when enabled, is ignored otherwise.
    do_write(4'd0, 8'd7, 7, 64'h0000_0007_0000_0005, 8'hFF, 2'b00, 1, "t7.wr");
    do_write(4'd0, 8'd0, 0, 64'hAA, 8'h00, 2'b00, 1, "t7.zstrb");
`ifdef AXIMUL_WSTRB_EN
    do_read(4'd0, 8'd1, 64'h0023, 8'h00, -1, 0, "t7.rd");
`else
    do_read(4'd0, 8'd1, 64'h04A6, 8'h00, -1, 0, "t7.rd");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
